// File: rtl/inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_prefetch_buf
// Description : Sequential instruction prefetch queue between the core fetch
//               port and a combinational instruction ROM. Consecutive words
//               are prefetched into a small FIFO and the head is delivered on
//               an address hit. Any mismatch flushes and re-steers the queue.
//               Optional feature macro: PREFETCH_STATS_EN (hit/miss counters).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch_buf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ce_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] pf_addr;

    logic full, hit, miss, push_pf;

    assign full = (count == FULL_CNT);

    // Hits come only from registered entries; rst gating forces all outputs
    // low while reset is asserted even if the core keeps requesting.
    // Misaligned addresses never hit, so they always take the miss path.
    assign hit = rst & req_ce_i & (count != '0) &
                 (addr_mem[rd_ptr] == req_addr_i) & (req_addr_i[1:0] == 2'b00);
    assign miss    = rst & req_ce_i & ~hit;
    assign push_pf = rst & ~miss & (state == RUN) & (~full | hit);

    assign inst_o       = hit ? data_mem[rd_ptr] : '0;
    assign inst_valid_o = hit;
    assign stall_o      = miss;
    assign rom_ce_o     = miss | push_pf;
    assign rom_addr_o   = miss ? req_addr_i : pf_addr;

    // Next-state: sleep once full with no demand, wake on a free slot or request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (~full | req_ce_i) state_nxt = RUN;
            RUN:     if (full & ~req_ce_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Queue bookkeeping: a miss flushes and restarts at the requested PC,
    // otherwise pop on hit and push on prefetch independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pf_addr <= '0;
        end else if (miss) begin
            rd_ptr  <= wr_ptr;
            wr_ptr  <= wr_ptr + 1'b1;
            count   <= (PTR_W+1)'(1);
            pf_addr <= req_addr_i + WORD_STEP;
        end else begin
            if (hit)     rd_ptr <= rd_ptr + 1'b1;
            if (push_pf) begin
                wr_ptr  <= wr_ptr + 1'b1;
                pf_addr <= pf_addr + WORD_STEP;
            end
            count <= count + (PTR_W+1)'(push_pf) - (PTR_W+1)'(hit);
        end
    end

    // Entry storage; validity is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (rom_ce_o) begin
            addr_mem[wr_ptr] <= rom_addr_o;
            data_mem[wr_ptr] <= rom_data_i;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + 32'd1;
            if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_prefetch_buf
// Description : Table-driven bench for inst_prefetch_buf. ROM word at A = A.
//               Expected counter values depend on PREFETCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_buf;

`ifdef PREFETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ce_i;
    logic [31:0] req_addr_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_o;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int passed = 0;
    int total  = 0;
    logic [31:0] m_hits, m_misses;

    inst_prefetch_buf #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_ce_i     (req_ce_i),
        .req_addr_i   (req_addr_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_o      (stall_o),
        .rom_ce_o     (rom_ce_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk = ~clk;

    // ROM model: each word holds its own address.
    assign rom_data_i = rom_addr_o;

    typedef struct packed {
        logic        ce;
        logic [31:0] addr;
        logic        valid;
        logic        stall;
        logic [31:0] inst;
        logic        rom_ce;
        logic [31:0] rom_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ce, logic [31:0] a, logic val, logic st,
                                logic [31:0] ins, logic rc, logic [31:0] ra);
        vec_t v;
        v.ce = ce; v.addr = a; v.valid = val; v.stall = st;
        v.inst = ins; v.rom_ce = rc; v.rom_addr = ra;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input vec_t v);
        req_ce_i   = v.ce;
        req_addr_i = v.addr;
    endtask

    task automatic check_row(input vec_t v, input int idx);
        string s;
        s = $sformatf("row%0d@%h", idx, v.addr);
        chk({s, " inst_valid"}, {31'd0, inst_valid_o}, {31'd0, v.valid});
        chk({s, " stall"},      {31'd0, stall_o},      {31'd0, v.stall});
        chk({s, " inst"},       inst_o,                v.inst);
        chk({s, " rom_ce"},     {31'd0, rom_ce_o},     {31'd0, v.rom_ce});
        chk({s, " rom_addr"},   rom_addr_o,            v.rom_addr);
        chk({s, " hit_cnt"},    hit_cnt_o,             m_hits);
        chk({s, " miss_cnt"},   miss_cnt_o,            m_misses);
        if (STATS) begin
            if (v.valid) m_hits++;
            if (v.stall) m_misses++;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        drive(v);
        #3;
        check_row(v, idx);
    endtask

    task automatic check_zero(input string name);
        chk({name, " inst"},       inst_o,                32'd0);
        chk({name, " inst_valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({name, " stall"},      {31'd0, stall_o},      32'd0);
        chk({name, " rom_ce"},     {31'd0, rom_ce_o},     32'd0);
        chk({name, " rom_addr"},   rom_addr_o,            32'd0);
        chk({name, " hit_cnt"},    hit_cnt_o,             32'd0);
        chk({name, " miss_cnt"},   miss_cnt_o,            32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_hits = 0; m_misses = 0;
        rst = 1'b0; req_ce_i = 1'b1; req_addr_i = 32'h0000_0040;

        // Sequential fetch from 0 (miss, then four hits)
        vecs.push_back(mk(1, 32'h00, 0, 1, 32'h00, 1, 32'h00));
        vecs.push_back(mk(1, 32'h00, 1, 0, 32'h00, 1, 32'h04));
        vecs.push_back(mk(1, 32'h04, 1, 0, 32'h04, 1, 32'h08));
        vecs.push_back(mk(1, 32'h08, 1, 0, 32'h08, 1, 32'h0C));
        vecs.push_back(mk(1, 32'h0C, 1, 0, 32'h0C, 1, 32'h10));
        // Branch to 0x40
        vecs.push_back(mk(1, 32'h10, 1, 0, 32'h10, 1, 32'h14));
        vecs.push_back(mk(1, 32'h14, 1, 0, 32'h14, 1, 32'h18));
        vecs.push_back(mk(1, 32'h40, 0, 1, 32'h00, 1, 32'h40));
        vecs.push_back(mk(1, 32'h40, 1, 0, 32'h40, 1, 32'h44));
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h44, 1, 32'h48));
        // Core idle for 6 cycles: fill to 4 then ROM disabled
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 1, 32'h4C));
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 1, 32'h50));
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 1, 32'h54));
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 0, 32'h58));
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 0, 32'h58));
        vecs.push_back(mk(0, 32'h48, 0, 0, 32'h00, 0, 32'h58));
        // Resume: back-to-back hits from the full queue
        vecs.push_back(mk(1, 32'h48, 1, 0, 32'h48, 0, 32'h58));
        vecs.push_back(mk(1, 32'h4C, 1, 0, 32'h4C, 1, 32'h58));
        vecs.push_back(mk(1, 32'h50, 1, 0, 32'h50, 1, 32'h5C));
        vecs.push_back(mk(1, 32'h54, 1, 0, 32'h54, 1, 32'h60));
        vecs.push_back(mk(1, 32'h58, 1, 0, 32'h58, 1, 32'h64));
        // Address wrap at the top of memory
        vecs.push_back(mk(1, 32'hFFFF_FFF8, 0, 1, 32'h0,         1, 32'hFFFF_FFF8));
        vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 32'h0000_0000, 1, 0, 32'h0,         1, 32'h0000_0004));
        vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 32'h4,         1, 32'h0000_0008));
        // Misaligned PC always misses
        vecs.push_back(mk(1, 32'h06, 0, 1, 32'h00, 1, 32'h06));
        vecs.push_back(mk(1, 32'h06, 0, 1, 32'h00, 1, 32'h06));
        vecs.push_back(mk(1, 32'h08, 0, 1, 32'h00, 1, 32'h08));
        vecs.push_back(mk(1, 32'h08, 1, 0, 32'h08, 1, 32'h0C));
        // Queue 3 entries ahead of the mid-run reset
        vecs.push_back(mk(1, 32'h100, 0, 1, 32'h00, 1, 32'h100));
        vecs.push_back(mk(0, 32'h100, 0, 0, 32'h00, 1, 32'h104));
        vecs.push_back(mk(0, 32'h100, 0, 0, 32'h00, 1, 32'h108));

        // Reset state while the core is already requesting
        #12;
        check_zero("reset");

        @(posedge clk);
        #1;
        rst = 1'b1;
        req_ce_i = 1'b0;
        req_addr_i = 32'h0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset with 3 entries queued: outputs drop immediately
        @(posedge clk);
        #1;
        req_ce_i = 1'b1;
        req_addr_i = 32'h104;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        m_hits = 0; m_misses = 0;

        // Release together with a request to 0: one-cycle miss, then hit
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(mk(1, 32'h00, 0, 1, 32'h00, 1, 32'h00));
        #3;
        check_row(mk(1, 32'h00, 0, 1, 32'h00, 1, 32'h00), 100);
        apply(mk(1, 32'h00, 1, 0, 32'h00, 1, 32'h04), 101);
        apply(mk(1, 32'h04, 1, 0, 32'h04, 1, 32'h08), 102);
        apply(mk(0, 32'h08, 0, 0, 32'h00, 1, 32'h0C), 103);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
